// File: rtl/banked_registers_if.sv
// Operand/write-port bundle between decode, EX/WB and the banked register file.
interface banked_registers_if #(
  parameter int DATA_W = 32,
  parameter int NUM_RD = 4
);
  logic                     en;
  logic [4:0]               i_mode;
  logic [4*NUM_RD-1:0]      i_rd_code;
  logic [DATA_W*NUM_RD-1:0] o_rd_reg;
  logic [NUM_RD-1:0]        o_rd_busy;
  logic [DATA_W-1:0]        i_pc_next;
  logic                     i_rd_en_ex;
  logic [3:0]               i_rd_code_ex;
  logic [DATA_W-1:0]        i_rd_reg_ex;
  logic                     i_rd_en_wb;
  logic [3:0]               i_rd_code_wb;
  logic [DATA_W-1:0]        i_rd_reg_wb;
  logic                     i_pend_en;
  logic [3:0]               i_pend_code;
  logic                     o_pend_full;
  logic                     o_pc_en;
  logic [DATA_W-1:0]        o_pc_reg;

  modport master (
    output en, i_mode, i_rd_code, i_pc_next,
    output i_rd_en_ex, i_rd_code_ex, i_rd_reg_ex,
    output i_rd_en_wb, i_rd_code_wb, i_rd_reg_wb,
    output i_pend_en, i_pend_code,
    input  o_rd_reg, o_rd_busy, o_pend_full, o_pc_en, o_pc_reg
  );

  modport slave (
    input  en, i_mode, i_rd_code, i_pc_next,
    input  i_rd_en_ex, i_rd_code_ex, i_rd_reg_ex,
    input  i_rd_en_wb, i_rd_code_wb, i_rd_reg_wb,
    input  i_pend_en, i_pend_code,
    output o_rd_reg, o_rd_busy, o_pend_full, o_pc_en, o_pc_reg
  );
endinterface

// File: rtl/banked_registers.sv
// ARMv4 banked general-purpose register file with a per-register
// pending-load scoreboard. Physical layout (index : contents):
//   0-7   R0-R7 shared        8-14  usr/sys R8-R14    15-21 fiq R8-R14
//   22-23 irq R13-R14         24-25 svc R13-R14       26-27 abt R13-R14
//   28-29 und R13-R14
module banked_registers #(
  parameter int DATA_W = 32,
  parameter int NUM_RD = 4,
  parameter int PEND_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  banked_registers_if.slave  bus
);

  localparam int NUM_PHYS = 30;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [PEND_W-1:0] CNT_ONE = 1;
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs    [NUM_PHYS];
  logic [PEND_W-1:0] cnt     [NUM_PHYS];
  logic [PEND_W-1:0] cnt_nxt [NUM_PHYS];

  // Logical code + mode to physical index; unknown modes fall back to usr.
  // Code 15 has no storage and maps to 0, callers must gate it.
  function automatic logic [4:0] phys(input logic [3:0] code, input logic [4:0] mode);
    logic [4:0] c;
    c = {1'b0, code};
    phys = c;
    if (code >= 4'd8 && code <= 4'd12) begin
      if (mode == MODE_FIQ) phys = c + 5'd7;
    end else if (code == 4'd13 || code == 4'd14) begin
      case (mode)
        MODE_FIQ: phys = c + 5'd7;
        MODE_IRQ: phys = c + 5'd9;
        MODE_SVC: phys = c + 5'd11;
        MODE_ABT: phys = c + 5'd13;
        MODE_UND: phys = c + 5'd15;
        default:  phys = c;
      endcase
    end else if (code == 4'd15) begin
      phys = 5'd0;
    end
  endfunction

  logic [4:0] p_ex, p_wb, p_pend;
  logic       ex_wr, wb_wr, pend_req, pend_inc, pend_dec;

  assign p_ex   = phys(bus.i_rd_code_ex, bus.i_mode);
  assign p_wb   = phys(bus.i_rd_code_wb, bus.i_mode);
  assign p_pend = phys(bus.i_pend_code, bus.i_mode);

  assign ex_wr    = bus.i_rd_en_ex && (bus.i_rd_code_ex != 4'd15);
  assign wb_wr    = bus.i_rd_en_wb && (bus.i_rd_code_wb != 4'd15);
  assign pend_req = bus.i_pend_en && (bus.i_pend_code != 4'd15);
  assign pend_inc = pend_req && (cnt[p_pend] != CNT_MAX);
  assign pend_dec = wb_wr && (cnt[p_wb] != '0);

  assign bus.o_pend_full = pend_req && (cnt[p_pend] == CNT_MAX);

  // A WB write to R15 takes precedence over EX for the redirect value.
  assign bus.o_pc_en  = (bus.i_rd_en_ex && bus.i_rd_code_ex == 4'd15) ||
                        (bus.i_rd_en_wb && bus.i_rd_code_wb == 4'd15);
  assign bus.o_pc_reg = (bus.i_rd_en_wb && bus.i_rd_code_wb == 4'd15) ?
                        bus.i_rd_reg_wb : bus.i_rd_reg_ex;

  // Combinational read ports; no bypass from the write ports.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [3:0] code;
    logic [4:0] p;
    assign code = bus.i_rd_code[4*k +: 4];
    assign p    = phys(code, bus.i_mode);
    assign bus.o_rd_reg[DATA_W*k +: DATA_W] = (code == 4'd15) ? bus.i_pc_next : regs[p];
    assign bus.o_rd_busy[k] = (code != 4'd15) && (cnt[p] != '0);
  end

  // Next pending count per register; a simultaneous set and retire cancel.
  always_comb begin
    for (int i = 0; i < NUM_PHYS; i++) begin
      cnt_nxt[i] = cnt[i];
      if (pend_inc && p_pend == 5'(i) && !(pend_dec && p_wb == 5'(i)))
        cnt_nxt[i] = cnt[i] + CNT_ONE;
      else if (pend_dec && p_wb == 5'(i) && !(pend_inc && p_pend == 5'(i)))
        cnt_nxt[i] = cnt[i] - CNT_ONE;
    end
  end

  // Register storage; EX is assigned last so it wins a same-target collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PHYS; i++) regs[i] <= '0;
    end else if (bus.en) begin
      if (wb_wr) regs[p_wb] <= bus.i_rd_reg_wb;
      if (ex_wr) regs[p_ex] <= bus.i_rd_reg_ex;
    end
  end

  // Pending-load counters, frozen while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PHYS; i++) cnt[i] <= '0;
    end else if (bus.en) begin
      for (int i = 0; i < NUM_PHYS; i++) cnt[i] <= cnt_nxt[i];
    end
  end

endmodule

// File: tb/tb_banked_registers.sv
// Bench for banked_registers: directed scenarios with literal expectations
// plus a randomized phase, all compared every cycle against a bank-level model.
module tb_banked_registers;
  localparam int DATA_W = 32;
  localparam int NUM_RD = 4;
  localparam int PEND_W = 2;
  localparam int MAXC   = (1 << PEND_W) - 1;

  localparam logic [4:0] USR = 5'b10000;
  localparam logic [4:0] FIQ = 5'b10001;
  localparam logic [4:0] IRQ = 5'b10010;
  localparam logic [4:0] SVC = 5'b10011;
  localparam logic [4:0] ABT = 5'b10111;
  localparam logic [4:0] UND = 5'b11011;
  localparam logic [4:0] SYS = 5'b11111;
  localparam logic [4:0] MODES [8] = '{USR, FIQ, IRQ, SVC, ABT, UND, SYS, 5'b00101};
  localparam logic [31:0] PC_IDLE = 32'h1234_5678;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  banked_registers_if #(.DATA_W(DATA_W), .NUM_RD(NUM_RD)) bus ();

  banked_registers #(.DATA_W(DATA_W), .NUM_RD(NUM_RD), .PEND_W(PEND_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit armed  = 0;

  // Model: values and pending counts keyed by (bank, register name).
  logic [31:0] mreg [int];
  int          mcnt [int];

  function automatic int bank_of(input logic [4:0] mode);
    case (mode)
      FIQ: return 1;
      IRQ: return 2;
      SVC: return 3;
      ABT: return 4;
      UND: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic int mkey(input logic [3:0] code, input logic [4:0] mode);
    int b;
    b = bank_of(mode);
    if (code < 8) return int'(code);
    if (code < 13) return (b == 1) ? 100 + int'(code) : int'(code);
    return 100 * b + int'(code);
  endfunction

  function automatic logic [31:0] mval(input int key);
    return mreg.exists(key) ? mreg[key] : 32'h0;
  endfunction

  function automatic int mpend(input int key);
    return mcnt.exists(key) ? mcnt[key] : 0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.en           = 1'b1;
    bus.i_mode       = USR;
    bus.i_rd_code    = '0;
    bus.i_pc_next    = PC_IDLE;
    bus.i_rd_en_ex   = 1'b0;
    bus.i_rd_code_ex = '0;
    bus.i_rd_reg_ex  = '0;
    bus.i_rd_en_wb   = 1'b0;
    bus.i_rd_code_wb = '0;
    bus.i_rd_reg_wb  = '0;
    bus.i_pend_en    = 1'b0;
    bus.i_pend_code  = '0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] code, input logic [4:0] mode,
                        input logic [31:0] ev, input logic eb);
    idle();
    bus.i_mode         = mode;
    bus.i_rd_code[3:0] = code;
    @(negedge clk);
    chk({name, "_val"}, bus.o_rd_reg[31:0], ev);
    chk({name, "_busy"}, bus.o_rd_busy[0], eb);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit use_wb, input logic [3:0] code, input logic [4:0] mode,
                    input logic [31:0] val);
    idle();
    bus.i_mode = mode;
    if (use_wb) begin
      bus.i_rd_en_wb = 1'b1; bus.i_rd_code_wb = code; bus.i_rd_reg_wb = val;
    end else begin
      bus.i_rd_en_ex = 1'b1; bus.i_rd_code_ex = code; bus.i_rd_reg_ex = val;
    end
    next_cycle();
  endtask

  task automatic pend(input logic [3:0] code, input logic [4:0] mode);
    idle();
    bus.i_mode      = mode;
    bus.i_pend_en   = 1'b1;
    bus.i_pend_code = code;
    next_cycle();
  endtask

  // Per-cycle compare against the model, then advance the model by one edge.
  initial begin
    int kp, kw, ke, cp, cw;
    bit inc, dec;
    logic [3:0] c;
    forever begin
      @(negedge clk);
      if (armed) begin
        for (int k = 0; k < NUM_RD; k++) begin
          c = bus.i_rd_code[4*k +: 4];
          chk($sformatf("rd_reg%0d", k), bus.o_rd_reg[DATA_W*k +: DATA_W],
              (c == 4'd15) ? bus.i_pc_next : mval(mkey(c, bus.i_mode)));
          chk($sformatf("rd_busy%0d", k), bus.o_rd_busy[k],
              (c != 4'd15) && (mpend(mkey(c, bus.i_mode)) > 0));
        end
        chk("pend_full", bus.o_pend_full, bus.i_pend_en && bus.i_pend_code != 4'd15 &&
            mpend(mkey(bus.i_pend_code, bus.i_mode)) == MAXC);
        chk("pc_en", bus.o_pc_en, (bus.i_rd_en_ex && bus.i_rd_code_ex == 4'd15) ||
            (bus.i_rd_en_wb && bus.i_rd_code_wb == 4'd15));
        chk("pc_reg", bus.o_pc_reg, (bus.i_rd_en_wb && bus.i_rd_code_wb == 4'd15) ?
            bus.i_rd_reg_wb : bus.i_rd_reg_ex);
      end
      if (rst) begin
        mreg.delete();
        mcnt.delete();
        armed = 1;
      end else if (bus.en) begin
        kp  = mkey(bus.i_pend_code, bus.i_mode);
        kw  = mkey(bus.i_rd_code_wb, bus.i_mode);
        ke  = mkey(bus.i_rd_code_ex, bus.i_mode);
        cp  = mpend(kp);
        cw  = mpend(kw);
        inc = bus.i_pend_en && bus.i_pend_code != 4'd15 && cp < MAXC;
        dec = bus.i_rd_en_wb && bus.i_rd_code_wb != 4'd15 && cw > 0;
        if (!(inc && dec && kp == kw)) begin
          if (inc) mcnt[kp] = cp + 1;
          if (dec) mcnt[kw] = cw - 1;
        end
        if (bus.i_rd_en_wb && bus.i_rd_code_wb != 4'd15) mreg[kw] = bus.i_rd_reg_wb;
        if (bus.i_rd_en_ex && bus.i_rd_code_ex != 4'd15) mreg[ke] = bus.i_rd_reg_ex;
      end
    end
  end

  initial begin
    rst = 1'b1;
    idle();
    next_cycle();
    next_cycle();
    rst = 1'b0;

    rd_chk("rst_r7", 4'd7, USR, 32'h0, 1'b0);

    // Banked R13 across usr/svc/sys.
    wr(0, 4'd13, USR, 32'h1111);
    wr(1, 4'd13, SVC, 32'h2222);
    rd_chk("r13_svc", 4'd13, SVC, 32'h2222, 1'b0);
    rd_chk("r13_usr", 4'd13, USR, 32'h1111, 1'b0);
    rd_chk("r13_sys", 4'd13, SYS, 32'h1111, 1'b0);

    // fiq-only R8, shared R0.
    wr(0, 4'd8, FIQ, 32'hA5A5);
    rd_chk("r8_usr", 4'd8, USR, 32'h0, 1'b0);
    rd_chk("r8_fiq", 4'd8, FIQ, 32'hA5A5, 1'b0);
    wr(0, 4'd0, FIQ, 32'h7);
    rd_chk("r0_irq", 4'd0, IRQ, 32'h7, 1'b0);

    // Same-target collision: EX wins.
    idle();
    bus.i_rd_en_ex = 1'b1; bus.i_rd_code_ex = 4'd3; bus.i_rd_reg_ex = 32'h10;
    bus.i_rd_en_wb = 1'b1; bus.i_rd_code_wb = 4'd3; bus.i_rd_reg_wb = 32'h20;
    next_cycle();
    rd_chk("r3_collide", 4'd3, USR, 32'h10, 1'b0);

    // R15 redirect: WB value wins, EX-only uses EX value.
    idle();
    bus.i_rd_en_ex = 1'b1; bus.i_rd_code_ex = 4'd15; bus.i_rd_reg_ex = 32'h100;
    bus.i_rd_en_wb = 1'b1; bus.i_rd_code_wb = 4'd15; bus.i_rd_reg_wb = 32'h200;
    @(negedge clk);
    chk("pc_en_both", bus.o_pc_en, 1'b1);
    chk("pc_reg_both", bus.o_pc_reg, 32'h200);
    @(posedge clk); #1;
    idle();
    bus.en = 1'b0;
    bus.i_rd_en_ex = 1'b1; bus.i_rd_code_ex = 4'd15; bus.i_rd_reg_ex = 32'h300;
    @(negedge clk);
    chk("pc_en_ex", bus.o_pc_en, 1'b1);
    chk("pc_reg_ex", bus.o_pc_reg, 32'h300);
    @(posedge clk); #1;

    // Saturate R5, then retire three times.
    pend(4'd5, USR);
    pend(4'd5, USR);
    pend(4'd5, USR);
    rd_chk("r5_sat", 4'd5, USR, 32'h0, 1'b1);
    idle();
    bus.i_pend_en = 1'b1; bus.i_pend_code = 4'd5;
    @(negedge clk);
    chk("pend_full_r5", bus.o_pend_full, 1'b1);
    @(posedge clk); #1;
    wr(1, 4'd5, USR, 32'h31);
    rd_chk("r5_ret1", 4'd5, USR, 32'h31, 1'b1);
    wr(1, 4'd5, USR, 32'h32);
    rd_chk("r5_ret2", 4'd5, USR, 32'h32, 1'b1);
    wr(1, 4'd5, USR, 32'h33);
    rd_chk("r5_ret3", 4'd5, USR, 32'h33, 1'b0);

    // Simultaneous set+retire at count 1, retire at count 0.
    pend(4'd5, USR);
    idle();
    bus.i_pend_en = 1'b1; bus.i_pend_code = 4'd5;
    bus.i_rd_en_wb = 1'b1; bus.i_rd_code_wb = 4'd5; bus.i_rd_reg_wb = 32'h44;
    next_cycle();
    rd_chk("r5_setret", 4'd5, USR, 32'h44, 1'b1);
    wr(1, 4'd6, USR, 32'h66);
    rd_chk("r6_underflow", 4'd6, USR, 32'h66, 1'b0);
    wr(1, 4'd5, USR, 32'h45);
    rd_chk("r5_clear", 4'd5, USR, 32'h45, 1'b0);

    // en=0 freeze, then reset clears pending state.
    pend(4'd4, USR);
    pend(4'd4, USR);
    wr(0, 4'd4, USR, 32'h55);
    idle();
    bus.en = 1'b0;
    bus.i_rd_en_ex = 1'b1; bus.i_rd_code_ex = 4'd4; bus.i_rd_reg_ex = 32'h99;
    bus.i_rd_en_wb = 1'b1; bus.i_rd_code_wb = 4'd4; bus.i_rd_reg_wb = 32'h77;
    bus.i_pend_en  = 1'b1; bus.i_pend_code  = 4'd4;
    @(negedge clk);
    chk("pend_full_r4", bus.o_pend_full, 1'b0);
    @(posedge clk); #1;
    rd_chk("r4_frozen", 4'd4, USR, 32'h55, 1'b1);
    wr(1, 4'd4, USR, 32'h56);
    rd_chk("r4_ret1", 4'd4, USR, 32'h56, 1'b1);
    idle();
    rst = 1'b1;
    bus.i_rd_en_ex = 1'b1; bus.i_rd_code_ex = 4'd4; bus.i_rd_reg_ex = 32'hAA;
    bus.i_pend_en  = 1'b1; bus.i_pend_code  = 4'd4;
    next_cycle();
    rst = 1'b0;
    rd_chk("r4_rst", 4'd4, USR, 32'h0, 1'b0);
    rd_chk("r15_read", 4'd15, USR, PC_IDLE, 1'b0);

    // Randomized traffic.
    repeat (4000) begin
      rst              = ($urandom_range(0, 199) == 0);
      bus.en           = ($urandom_range(0, 9) != 0);
      bus.i_mode       = MODES[$urandom_range(0, 7)];
      bus.i_rd_code    = $urandom;
      bus.i_pc_next    = $urandom;
      bus.i_rd_en_ex   = $urandom_range(0, 1);
      bus.i_rd_code_ex = 4'($urandom_range(0, 15));
      bus.i_rd_reg_ex  = $urandom;
      bus.i_rd_en_wb   = ($urandom_range(0, 9) < 4);
      bus.i_rd_code_wb = 4'($urandom_range(0, 15));
      bus.i_rd_reg_wb  = $urandom;
      bus.i_pend_en    = $urandom_range(0, 1);
      bus.i_pend_code  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                     : 4'($urandom_range(4, 6));
      next_cycle();
    end

    rst = 1'b0;
    idle();
    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/banked_registers.md
# banked_registers

Parametrised ARMv4 general-purpose register file with per-mode banking (USR/SYS, FIQ, IRQ, SVC, ABT, UND), a configurable number of read ports, and a load-pending scoreboard. It sits between decode and the EX/WB stages of the core. It supplies operands, flags operands whose load is still outstanding, accepts the EX and WB write ports, and redirects the PC on writes to R15.

## Interface
Parameters:
- DATA_W, 32, register width
- NUM_RD, 4, number of read ports
- PEND_W, 2, width of each pending-load counter (max outstanding loads per register = 2^PEND_W-1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- en  in  1  global update enable; when 0, no register or scoreboard state changes
- i_mode  in  5  current CPSR mode: 10000 usr, 10001 fiq, 10010 irq, 10011 svc, 10111 abt, 11011 und, 11111 sys
- i_rd_code  in  4*NUM_RD  logical read codes; port k uses bits [4k+3:4k]
- o_rd_reg  out  DATA_W*NUM_RD  read data, port k
- o_rd_busy  out  NUM_RD  port k reads a register with pending count > 0
- i_pc_next  in  DATA_W  value returned for reads of R15
- i_rd_en_ex, i_rd_code_ex[3:0], i_rd_reg_ex[DATA_W-1:0]  in  EX write port
- i_rd_en_wb, i_rd_code_wb[3:0], i_rd_reg_wb[DATA_W-1:0]  in  WB write port; also retires one pending load
- i_pend_en  in  1  a load targeting i_pend_code issues this cycle
- i_pend_code  in  4  logical destination of the issuing load
- o_pend_full  out  1  issuing load hits a saturated counter; the issue stage must stall
- o_pc_en  out  1  a write to R15 occurs this cycle
- o_pc_reg  out  DATA_W  PC write value

## Operation
- Physical storage is 30 registers:
  - R0–R7 shared by all modes.
  - R8–R12 in two banks: usr and fiq.
  - R13–R14 in six banks: usr, fiq, irq, svc, abt, und.
  - sys and any undefined i_mode value map to the usr bank.
- Logical-to-physical mapping uses i_mode of the cycle in which the access occurs. This applies to reads, both writes, and scoreboard set/clear alike.
- Reads are combinational. Code 15 returns i_pc_next, and o_rd_busy is 0 for code 15. There is no write bypass: a read returns the stored value.
- Writes (code ≠ 15), taken at posedge when en = 1:
  - EX and WB may target the same physical register in the same cycle; EX wins.
  - Different targets both write.
- R15 writes:
  - o_pc_en = (EX en & code == 15) | (WB en & code == 15).
  - o_pc_reg = WB value if the WB port targets R15, else the EX value.
  - These outputs are combinational and independent of en.
- Scoreboard: one PEND_W-bit counter per physical register.
  - Increment: i_pend_en & code ≠ 15 & not saturated.
  - Decrement: i_rd_en_wb & code_wb ≠ 15 & count > 0. EX writes never decrement.
  - Increment and decrement on the same physical register in the same cycle: count unchanged.
  - Decrement at count 0: ignored.
  - Increment at max: ignored, and o_pend_full is asserted.
  - i_pend_en with code 15: ignored.
- o_pend_full = i_pend_en & code ≠ 15 & target count == max. It is combinational and asserted even when en = 0.

## Timing
- Reset (rst high at posedge): all 30 registers = 0, all counters = 0.
- Outputs after reset:
  - o_rd_reg = 0 for codes 0–14; i_pc_next for code 15.
  - o_rd_busy = 0.
  - o_pend_full = 0 unless an issuing load targets a register at max with PEND_W = 0. PEND_W ≥ 1 is required.
  - o_pc_en/o_pc_reg follow their inputs.
- Reset has priority over en and over simultaneous writes or pending sets. It clears mid-operation pending counts with no residual busy.
- Write latency: the value is visible on o_rd_reg in the cycle after the posedge at which it was written.
- Busy latency:
  - Set at posedge N → o_rd_busy high from cycle N+1.
  - The WB retire at posedge M that brings the count to 0 → busy low from cycle M+1.
- A mode change between pending set and WB retire retires against the physical register selected by the retire-cycle mode. The pipeline must not reorder these.
- en = 0 freezes registers and counters; combinational outputs stay live.

## Test plan
- Reset, then in usr mode write R13 = 0x1111 via EX. Switch i_mode to svc and write R13 = 0x2222 via WB. Read R13 in svc → 0x2222; in usr → 0x1111; in sys → 0x1111.
- fiq mode: write R8 = 0xA5A5; read R8 in usr → 0; in fiq → 0xA5A5. Write R0 in fiq = 7; read R0 in irq → 7.
- Same cycle, EX and WB both write R3 (EX = 0x10, WB = 0x20) → next cycle R3 = 0x10. EX R15 = 0x100 with WB R15 = 0x200 → o_pc_en = 1, o_pc_reg = 0x200 in that cycle.
- PEND_W = 2: three pending sets on R5 → busy = 1 and count = 3. A fourth set → o_pend_full = 1 and the count stays 3. Three WB writes to R5 → busy drops in the cycle after the third.
- Pending set and WB retire on R5 in the same cycle at count 1 → count stays 1, busy stays 1. WB retire on R6 at count 0 → no change and no underflow.
- With R4 count 2 and R4 = 0x55, hold en = 0 with writes and sets applied → nothing changes. Assert rst → R4 = 0 and busy = 0 next cycle. A read of code 15 always returns i_pc_next with busy = 0.
